// File: rtl/rf_exec_ctrl.sv
// rf_exec_ctrl: four-state controller that runs one instruction at a time
// against an external register file (read, execute, write back).
module rf_exec_ctrl (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       inst_valid,
    output logic       inst_ready,
    input  logic [2:0] inst_op,
    input  logic [2:0] inst_rd,
    input  logic [2:0] inst_rs,
    input  logic [2:0] inst_rt,
    input  logic [7:0] inst_imm,
    output logic [2:0] RX,
    output logic [2:0] RY,
    input  logic [7:0] busX,
    input  logic [7:0] busY,
    output logic       WEN,
    output logic [2:0] RW,
    output logic [7:0] busW,
    output logic       done,
    output logic [7:0] result,
    output logic       carry
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SLT  = 3'd5,
        OP_MOVI = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    state_e     state_q, state_d;
    op_e        op_q;
    logic [2:0] rd_q;
    logic [2:0] rx_q, ry_q, rw_q;
    logic [7:0] imm_q;
    logic [7:0] a_q, b_q;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d;
    logic       handshake;
    logic [8:0] sum9, diff9;

    assign handshake = inst_valid && (state_q == S_IDLE);

    // Nine-bit add/subtract so bit 8 is the ADD carry or the SUB borrow.
    assign sum9  = {1'b0, a_q} + {1'b0, b_q};
    assign diff9 = {1'b0, a_q} - {1'b0, b_q};

    // State register; reset wins over a simultaneous handshake.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed IDLE->READ->EXEC->WRITE->IDLE walk.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (handshake) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ALU: NOP (and any unlisted code) keeps the previous result and carry.
    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        case (op_q)
            OP_ADD: begin
                result_d = sum9[7:0];
                carry_d  = sum9[8];
            end
            OP_SUB: begin
                result_d = diff9[7:0];
                carry_d  = diff9[8];
            end
            OP_AND:  result_d = a_q & b_q;
            OP_OR:   result_d = a_q | b_q;
            OP_XOR:  result_d = a_q ^ b_q;
            OP_SLT:  result_d = {7'd0, ($signed(a_q) < $signed(b_q))};
            OP_MOVI: result_d = imm_q;
            default: ;
        endcase
    end

    // Datapath registers: latch instruction on accept, operands in READ,
    // result and write address in EXEC.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q     <= OP_NOP;
            rd_q     <= 3'd0;
            imm_q    <= 8'd0;
            rx_q     <= 3'd0;
            ry_q     <= 3'd0;
            rw_q     <= 3'd0;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            result_q <= 8'd0;
            carry_q  <= 1'b0;
        end else begin
            if (handshake) begin
                op_q  <= op_e'(inst_op);
                rd_q  <= inst_rd;
                imm_q <= inst_imm;
                // Read addresses change only here, so they hold outside READ.
                rx_q  <= inst_rs;
                ry_q  <= inst_rt;
            end
            if (state_q == S_READ) begin
                a_q <= busX;
                b_q <= busY;
            end
            if (state_q == S_EXEC) begin
                result_q <= result_d;
                carry_q  <= carry_d;
                rw_q     <= rd_q;
            end
        end
    end

    assign inst_ready = (state_q == S_IDLE);
    assign done       = (state_q == S_WRITE);
    // R0 is never written, and NOP retires without touching the file.
    assign WEN        = done && (op_q != OP_NOP) && (rd_q != 3'd0);
    assign RX         = rx_q;
    assign RY         = ry_q;
    assign RW         = rw_q;
    assign busW       = result_q;
    assign result     = result_q;
    assign carry      = carry_q;

endmodule

// File: tb/tb_rf_exec_ctrl.sv
// tb_rf_exec_ctrl: drives rf_exec_ctrl against a behavioural register file and
// compares every retire with an arithmetic reference model.
module tb_rf_exec_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       inst_valid;
    logic       inst_ready;
    logic [2:0] inst_op, inst_rd, inst_rs, inst_rt;
    logic [7:0] inst_imm;
    logic [2:0] RX, RY, RW;
    logic [7:0] busX, busY, busW;
    logic       WEN, done, carry;
    logic [7:0] result;

    rf_exec_ctrl dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_op    (inst_op),
        .inst_rd    (inst_rd),
        .inst_rs    (inst_rs),
        .inst_rt    (inst_rt),
        .inst_imm   (inst_imm),
        .RX         (RX),
        .RY         (RY),
        .busX       (busX),
        .busY       (busY),
        .WEN        (WEN),
        .RW         (RW),
        .busW       (busW),
        .done       (done),
        .result     (result),
        .carry      (carry)
    );

    always #5 Clk = ~Clk;

    // Register file: R0 reads as zero; preload port for bench setup.
    logic [7:0] rf [8];
    logic       pl_en;
    logic [2:0] pl_addr;
    logic [7:0] pl_data;

    always @(posedge Clk) begin
        if (pl_en) rf[pl_addr] <= pl_data;
        else if (WEN && RW != 3'd0) rf[RW] <= busW;
    end

    assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
    assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0] m_reg [8];
    logic [7:0] m_result;
    logic       m_carry;

    logic [2:0] cur_op, cur_rd, cur_rs, cur_rt;
    logic [7:0] cur_imm;
    int         acc_cyc;
    int         first_cyc;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rf_val(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : rf[a];
    endfunction

    // Instruction semantics from plain integer arithmetic.
    function automatic void model_exec(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] imm);
        int s, sa, sb;
        sa = int'(a);
        sb = int'(b);
        if (sa > 127) sa = sa - 256;
        if (sb > 127) sb = sb - 256;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                m_result = 8'(s % 256);
                m_carry  = (s > 255);
            end
            3'd1: begin
                s = 256 + int'(a) - int'(b);
                m_result = 8'(s % 256);
                m_carry  = (int'(a) < int'(b));
            end
            3'd2: m_result = a & b;
            3'd3: m_result = a | b;
            3'd4: m_result = a ^ b;
            3'd5: m_result = (sa < sb) ? 8'h01 : 8'h00;
            3'd6: m_result = imm;
            default: ;
        endcase
    endfunction

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
        m_reg[a] = (a == 3'd0) ? 8'h00 : d;
    endtask

    // Present an instruction, wait (bounded) for ready, take the handshake edge.
    task automatic accept(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [7:0] imm);
        inst_op    = op;
        inst_rd    = rd;
        inst_rs    = rs;
        inst_rt    = rt;
        inst_imm   = imm;
        inst_valid = 1'b1;
        for (int i = 0; i < 8 && !inst_ready; i++) tick();
        check("accept_ready", 32'(inst_ready), 32'd1);
        cur_op  = op;
        cur_rd  = rd;
        cur_rs  = rs;
        cur_rt  = rt;
        cur_imm = imm;
        tick();
        acc_cyc = cyc;
    endtask

    // Walk READ, EXEC, WRITE, IDLE for the accepted instruction.
    task automatic retire(input bit garbage, input bit hold_valid);
        logic [7:0] a, b;
        logic       exp_wen;
        check("read_ready", 32'(inst_ready), 32'd0);
        check("read_RX", 32'(RX), 32'(cur_rs));
        check("read_RY", 32'(RY), 32'(cur_rt));
        check("read_wen", 32'(WEN), 32'd0);
        check("read_done", 32'(done), 32'd0);
        if (!hold_valid) inst_valid = 1'b0;
        if (garbage) begin
            inst_op  = 3'($urandom);
            inst_rd  = 3'($urandom);
            inst_rs  = 3'($urandom);
            inst_rt  = 3'($urandom);
            inst_imm = 8'($urandom);
        end
        tick();
        check("exec_ready", 32'(inst_ready), 32'd0);
        check("exec_wen", 32'(WEN), 32'd0);
        check("exec_done", 32'(done), 32'd0);
        tick();
        a = m_reg[cur_rs];
        b = m_reg[cur_rt];
        model_exec(cur_op, a, b, cur_imm);
        exp_wen = (cur_op != 3'd7) && (cur_rd != 3'd0);
        check("write_ready", 32'(inst_ready), 32'd0);
        check("write_done", 32'(done), 32'd1);
        check("write_wen", 32'(WEN), 32'(exp_wen));
        check("write_RW", 32'(RW), 32'(cur_rd));
        check("write_busW", 32'(busW), 32'(m_result));
        check("write_result", 32'(result), 32'(m_result));
        check("write_carry", 32'(carry), 32'(m_carry));
        if (exp_wen) m_reg[cur_rd] = m_result;
        tick();
        check("idle_ready", 32'(inst_ready), 32'd1);
        check("idle_done", 32'(done), 32'd0);
        check("idle_wen", 32'(WEN), 32'd0);
        check("idle_RX_hold", 32'(RX), 32'(cur_rs));
        check("idle_rf_rd", 32'(rf_val(cur_rd)), 32'(m_reg[cur_rd]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_valid = 1'b0;
        inst_op    = 3'd0;
        inst_rd    = 3'd0;
        inst_rs    = 3'd0;
        inst_rt    = 3'd0;
        inst_imm   = 8'd0;
        pl_en      = 1'b0;
        pl_addr    = 3'd0;
        pl_data    = 8'd0;
        Rst        = 1'b1;
        m_result   = 8'd0;
        m_carry    = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) preload(3'(i), 8'h00);
        preload(3'd1, 8'hF0);
        preload(3'd2, 8'h20);
        Rst = 1'b0;

        // Reset state.
        check("rst_ready", 32'(inst_ready), 32'd1);
        check("rst_wen", 32'(WEN), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_RX", 32'(RX), 32'd0);
        check("rst_RY", 32'(RY), 32'd0);
        check("rst_RW", 32'(RW), 32'd0);
        check("rst_busW", 32'(busW), 32'd0);
        check("rst_result", 32'(result), 32'd0);

        // ADD with carry out.
        accept(3'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        retire(1'b0, 1'b0);
        check("add_R3", 32'(rf_val(3'd3)), 32'h10);
        check("add_carry", 32'(carry), 32'd1);

        // SUB with borrow.
        accept(3'd1, 3'd4, 3'd2, 3'd1, 8'h00);
        retire(1'b0, 1'b0);
        check("sub_R4", 32'(rf_val(3'd4)), 32'h30);
        check("sub_carry", 32'(carry), 32'd1);

        // Signed compare: -16 < 32.
        accept(3'd5, 3'd5, 3'd1, 3'd2, 8'h00);
        retire(1'b0, 1'b0);
        check("slt_R5", 32'(rf_val(3'd5)), 32'h01);

        // MOVI to R0 retires without a write.
        accept(3'd6, 3'd0, 3'd0, 3'd0, 8'hAA);
        retire(1'b0, 1'b0);
        check("movi_r0_busX", 32'(busX), 32'h00);

        // NOP keeps result and carry of the MOVI above.
        accept(3'd7, 3'd1, 3'd2, 3'd3, 8'h55);
        retire(1'b0, 1'b0);
        check("nop_result", 32'(result), 32'hAA);
        check("nop_R1", 32'(rf_val(3'd1)), 32'hF0);

        // Inputs scrambled during READ must not matter.
        accept(3'd2, 3'd6, 3'd1, 3'd2, 8'h00);
        retire(1'b1, 1'b0);
        check("garbage_R6", 32'(rf_val(3'd6)), 32'h20);

        // Back-to-back with inst_valid held; second uses first's destination.
        accept(3'd0, 3'd7, 3'd1, 3'd2, 8'h00);
        first_cyc = acc_cyc;
        inst_op = 3'd3;
        inst_rd = 3'd3;
        inst_rs = 3'd7;
        inst_rt = 3'd1;
        retire(1'b0, 1'b1);
        accept(3'd3, 3'd3, 3'd7, 3'd1, 8'h00);
        check("b2b_gap", 32'(acc_cyc - first_cyc), 32'd4);
        retire(1'b0, 1'b0);
        check("b2b_R3", 32'(rf_val(3'd3)), 32'hF0);

        // Reset beats a simultaneous handshake.
        inst_op    = 3'd0;
        inst_rd    = 3'd2;
        inst_rs    = 3'd5;
        inst_rt    = 3'd6;
        inst_valid = 1'b1;
        Rst        = 1'b1;
        tick();
        Rst        = 1'b0;
        inst_valid = 1'b0;
        m_result   = 8'd0;
        m_carry    = 1'b0;
        check("rprio_ready", 32'(inst_ready), 32'd1);
        check("rprio_RX", 32'(RX), 32'd0);
        tick();
        check("rprio_done", 32'(done), 32'd0);
        check("rprio_ready2", 32'(inst_ready), 32'd1);

        // Reset during EXEC of XOR aborts it.
        accept(3'd4, 3'd6, 3'd1, 3'd2, 8'h00);
        inst_valid = 1'b0;
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("abort_ready", 32'(inst_ready), 32'd1);
        check("abort_wen", 32'(WEN), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_outs", 32'({RX, RY, RW, busW, result, carry}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort_quiet", 32'({WEN, done}), 32'd0);
            tick();
        end
        check("abort_R6", 32'(rf_val(3'd6)), 32'(m_reg[6]));

        // Randomized instructions against the model.
        for (int n = 0; n < 24; n++) begin
            accept(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            retire(1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_exec_ctrl.md
RF_EXEC_CTRL -- requirements
Module: rf_exec_ctrl

Interface
REQ-001 The module SHALL have one clock and reset; reset is synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock shared with register_file.
REQ-003 Rst  input  1  synchronous active-high reset.
REQ-004 inst_valid  input  1  instruction present on inst_* this cycle.
REQ-005 inst_ready  output  1  controller can accept an instruction.
REQ-006 inst_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 MOVI, 7 NOP.
REQ-007 inst_rd, inst_rs, inst_rt  input  3 each  destination and source register indices.
REQ-008 inst_imm  input  8  immediate for MOVI.
REQ-009 RX, RY  output  3 each  read addresses driven to register_file.
REQ-010 busX, busY  input  8 each  combinational read data from register_file.
REQ-011 WEN, RW, busW  output  1/3/8  write enable, write address, write data to register_file.
REQ-012 done  output  1  one-cycle pulse when an instruction retires.
REQ-013 result  output  8  last computed value, held until the next retire.
REQ-014 carry  output  1  ADD carry-out / SUB borrow of the last ADD/SUB, held otherwise.

Function
REQ-015 FSM states SHALL be IDLE, READ, EXEC, WRITE; single instruction in flight, no pipelining.
REQ-016 inst_ready SHALL be 1 only in IDLE; handshake occurs on the rising edge where inst_valid & inst_ready.
REQ-017 On handshake, op/rd/rs/rt/imm SHALL be latched internally and the state SHALL go IDLE->READ; inst_* changes afterwards have no effect.
REQ-018 In READ, RX=latched rs and RY=latched rt; at the end of READ, busX/busY SHALL be captured into operand registers; READ->EXEC.
REQ-019 Outside READ, RX and RY SHALL hold their last driven values (0 after reset).
REQ-020 In EXEC, an 8-bit result SHALL be computed from the captured operands and registered; EXEC->WRITE.
REQ-021 ADD/SUB wrap modulo 256; carry = bit 8 of the 9-bit sum for ADD; carry = 1 when A < B unsigned for SUB.
REQ-022 AND/OR/XOR are bitwise; SLT gives 8'h01 if A < B as signed two's-complement, else 8'h00; MOVI gives imm.
REQ-023 NOP SHALL leave result and carry unchanged and SHALL NOT assert WEN.
REQ-024 In WRITE, RW=rd and busW=result; WEN=1 for exactly this one cycle unless op is NOP or rd==0.
REQ-025 done SHALL pulse for one cycle in WRITE for every instruction, including NOP and rd==0; WRITE->IDLE.
REQ-026 Latency: handshake at edge T, WEN/done high during cycle T+3, inst_ready high again in cycle T+4; throughput is one instruction per 4 cycles.
REQ-027 rs==rd or rt==rd SHALL read the old value; the new value is visible to the next instruction.
REQ-028 WEN SHALL be 0 in every state other than WRITE.

Reset
REQ-029 With Rst high at a rising edge, state SHALL become IDLE; WEN, done, carry=0; RX, RY, RW, busW, result=0; inst_ready=1 in the next cycle.
REQ-030 A Rst mid-instruction SHALL abort it: no WEN, no done; the register_file is unchanged.
REQ-031 Rst SHALL take priority over a simultaneous handshake.

Verification
REQ-032 Preload R1=8'hF0, R2=8'h20; ADD rd=3 rs=1 rt=2 -> WEN pulse with RW=3, busW=8'h10 at T+3; carry=1, done=1; R3 reads 8'h10.
REQ-033 SUB rd=4 rs=2 rt=1 (8'h20-8'hF0) -> R4=8'h30, carry=1; SLT rd=5 rs=1 rt=2 -> R5=8'h01 (signed -16 < 32).
REQ-034 MOVI rd=0 imm=8'hAA -> done pulses, WEN stays 0, R0 reads 8'h00; NOP -> done pulses, result and carry unchanged.
REQ-035 Back-to-back: hold inst_valid high with two instructions -> inst_ready=0 for 3 cycles after each accept; second accepted exactly 4 cycles after first; instruction 2 sources rd of instruction 1 and sees its new value.
REQ-036 Assert Rst during EXEC of XOR rd=6 -> no WEN, no done, R6 unchanged, all outputs 0, inst_ready=1 the next cycle.
REQ-037 Change inst_* to garbage during READ -> retired result matches the latched instruction.
